// File: rtl/mmio_periph_hub_pkg.sv
// mmio_periph_hub_pkg: register offsets and sticky-flag bit indices for the MMIO hub
package mmio_periph_hub_pkg;
  localparam logic [7:0] MMIO_UART_CTRL = 8'h00;
  localparam logic [7:0] MMIO_UART_RX   = 8'h04;
  localparam logic [7:0] MMIO_UART_TX   = 8'h08;
  localparam logic [7:0] MMIO_CYCLE     = 8'h10;
  localparam logic [7:0] MMIO_RETIRED   = 8'h14;
  localparam logic [7:0] MMIO_CNT_CLR   = 8'h18;
  localparam logic [7:0] MMIO_FLAGS     = 8'h1C;
  localparam logic [7:0] MMIO_BTN_STAT  = 8'h20;
  localparam logic [7:0] MMIO_BTN_DATA  = 8'h24;
  localparam logic [7:0] MMIO_SW        = 8'h28;
  localparam logic [7:0] MMIO_LED       = 8'h30;
  localparam int FLAG_TX_DROP = 0;
  localparam int FLAG_RX_OVF  = 1;
  localparam int FLAG_BTN_OVF = 2;
endpackage

// File: rtl/mmio_periph_hub_fifo.sv
// io_sync_fifo: sync FIFO (clk, rst active-low, push/wdata in, pop/rdata head out, full/empty), push accepted on full when popping
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty   = wptr == rptr;
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/mmio_periph_hub.sv
// mmio_periph_hub: MMIO hub (req_* bus in, rsp_rdata out; UART rx/tx handshakes; counters; buttons/switches in; leds out)
module mmio_periph_hub
  import mmio_periph_hub_pkg::*;
#(
  parameter int NUM_BTN        = 3,
  parameter int NUM_SW         = 2,
  parameter int NUM_LED        = 6,
  parameter int BTN_FIFO_DEPTH = 8,
  parameter int RX_FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [7:0]         req_addr,
  input  logic [3:0]         req_we,
  input  logic [31:0]        req_wdata,
  output logic [31:0]        rsp_rdata,
  input  logic               inst_retire,
  input  logic [7:0]         uart_rx_data,
  input  logic               uart_rx_valid,
  output logic               uart_rx_ready,
  output logic [7:0]         uart_tx_data,
  output logic               uart_tx_valid,
  input  logic               uart_tx_ready,
  input  logic [NUM_BTN-1:0] buttons,
  input  logic [NUM_SW-1:0]  switches,
  output logic [NUM_LED-1:0] leds
);
  logic [7:0] addr;
  logic rd, wr, unused;
  logic [7:0] rx_rdata;
  logic rx_full, rx_empty, rx_block_q;
  logic [NUM_BTN-1:0] btn_rdata, btn_q;
  logic btn_full, btn_empty, btn_rise, btn_pop;
  logic [2:0] flags, flag_set, flag_clr;
  logic [31:0] cyc, ret, rdata;
  logic tx_wr, cnt_clr;
  assign addr     = {req_addr[7:2], 2'b00};
  assign rd       = req_valid & ~|req_we;
  assign wr       = req_valid & |req_we;
  assign unused   = ^{req_addr[1:0], req_wdata[31:8]};
  assign tx_wr    = wr & (addr == MMIO_UART_TX);
  assign cnt_clr  = wr & (addr == MMIO_CNT_CLR);
  assign btn_pop  = rd & (addr == MMIO_BTN_DATA);
  assign btn_rise = |(buttons & ~btn_q);
  assign uart_rx_ready = ~rx_full;
  // rx overflow flags only the first cycle a byte is held off, not every stalled cycle
  assign flag_set[FLAG_TX_DROP] = tx_wr & uart_tx_valid;
  assign flag_set[FLAG_RX_OVF]  = uart_rx_valid & rx_full & ~rx_block_q;
  assign flag_set[FLAG_BTN_OVF] = btn_rise & btn_full & ~btn_pop;
  assign flag_clr = (wr & req_we[0] & (addr == MMIO_FLAGS)) ? req_wdata[2:0] : 3'b0;
  io_sync_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(uart_rx_valid & ~rx_full), .pop(rd & (addr == MMIO_UART_RX)),
    .wdata(uart_rx_data), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
  );
  io_sync_fifo #(.WIDTH(NUM_BTN), .DEPTH(BTN_FIFO_DEPTH)) u_btn_fifo (
    .clk(clk), .rst(rst), .push(btn_rise), .pop(btn_pop),
    .wdata(buttons), .rdata(btn_rdata), .full(btn_full), .empty(btn_empty)
  );
  always_comb begin
    rdata = '0;
    case (addr)
      MMIO_UART_CTRL: rdata = {29'b0, flags[FLAG_TX_DROP], ~rx_empty, ~uart_tx_valid};
      MMIO_UART_RX:   rdata = rx_empty ? '0 : 32'(rx_rdata);
      MMIO_CYCLE:     rdata = cyc;
      MMIO_RETIRED:   rdata = ret;
      MMIO_FLAGS:     rdata = 32'(flags);
      MMIO_BTN_STAT:  rdata = 32'(btn_empty);
      MMIO_BTN_DATA:  rdata = btn_empty ? '0 : 32'(btn_rdata);
      MMIO_SW:        rdata = 32'(switches);
      MMIO_LED:       rdata = 32'(leds);
      default:        rdata = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_rdata     <= '0;
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= '0;
      leds          <= '0;
      cyc           <= '0;
      ret           <= '0;
      flags         <= '0;
      btn_q         <= '0;
      rx_block_q    <= 1'b0;
    end else begin
      btn_q      <= buttons;
      rx_block_q <= uart_rx_valid & rx_full;
      flags      <= (flags & ~flag_clr) | flag_set;
      cyc        <= cnt_clr ? '0 : cyc + 32'd1;
      ret        <= cnt_clr ? '0 : ret + 32'(inst_retire);
      if (rd) rsp_rdata <= rdata;
      if (wr & req_we[0] & (addr == MMIO_LED)) leds <= req_wdata[NUM_LED-1:0];
      if (tx_wr & ~uart_tx_valid) begin
        uart_tx_valid <= 1'b1;
        uart_tx_data  <= req_wdata[7:0];
      end else if (uart_tx_valid & uart_tx_ready) uart_tx_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mmio_periph_hub.sv
// tb_mmio_periph_hub: scoreboard bench for mmio_periph_hub with directed vectors
module tb_mmio_periph_hub;
  logic clk = 0, rst = 0;
  logic req_valid = 0, inst_retire = 0, uart_rx_valid = 0, uart_tx_ready = 0;
  logic [7:0] req_addr = 0, uart_rx_data = 0;
  logic [3:0] req_we = 0;
  logic [31:0] req_wdata = 0;
  logic [2:0] buttons = 0;
  logic [1:0] switches = 0;
  logic [31:0] rsp_rdata;
  logic uart_rx_ready, uart_tx_valid;
  logic [7:0] uart_tx_data;
  logic [5:0] leds;
  logic rd_pend = 0;
  int n_chk = 0, n_fail = 0;
  typedef struct {string nm; logic [31:0] v;} exp_t;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  mmio_periph_hub dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .rsp_rdata(rsp_rdata), .inst_retire(inst_retire),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .buttons(buttons), .switches(switches), .leds(leds)
  );
  always @(posedge clk) rd_pend <= rst && req_valid && (req_we == 4'b0);
  always @(negedge clk) begin
    if (rd_pend) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: rsp_rdata=%h with no expectation", rsp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rsp_rdata !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.nm, rsp_rdata, e.v);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
    req_valid = 1; req_addr = a; req_we = 0;
    exp_q.push_back('{nm, e});
    @(posedge clk); #1;
    req_valid = 0;
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
    req_valid = 1; req_addr = a; req_we = we; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0; req_we = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  initial begin
    int exp_ret;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    chk("reset_rsp", rsp_rdata, 0);
    chk("reset_rx_ready", 32'(uart_rx_ready), 1);
    chk("reset_tx_valid", 32'(uart_tx_valid), 0);
    chk("reset_tx_data", 32'(uart_tx_data), 0);
    chk("reset_leds", 32'(leds), 0);
    rd(8'h00, 32'h1, "reset_status");
    rd(8'h30, 32'h0, "reset_led_reg");
    for (int i = 0; i < 4; i++) begin
      uart_rx_valid = 1; uart_rx_data = 8'h41 + 8'(i);
      idle(1);
    end
    uart_rx_data = 8'h45;
    chk("rx_full_ready", 32'(uart_rx_ready), 0);
    idle(3);
    chk("rx_held_ready", 32'(uart_rx_ready), 0);
    uart_rx_valid = 0;
    rd(8'h00, 32'h3, "status_rx_nonempty");
    rd(8'h1C, 32'h2, "flags_rx_ovf");
    for (int i = 0; i < 4; i++) rd(8'h04, 32'h41 + 32'(i), "rx_pop_order");
    rd(8'h04, 32'h0, "rx_pop_empty");
    wr(8'h1C, 32'h2, 4'hF);
    rd(8'h1C, 32'h0, "flags_rx_w1c");
    wr(8'h08, 32'h55, 4'hF);
    chk("tx_valid_set", 32'(uart_tx_valid), 1);
    chk("tx_data_55", 32'(uart_tx_data), 32'h55);
    wr(8'h08, 32'h66, 4'hF);
    chk("tx_data_kept", 32'(uart_tx_data), 32'h55);
    rd(8'h00, 32'h4, "status_tx_busy_drop");
    rd(8'h1C, 32'h1, "flags_tx_drop");
    wr(8'h1C, 32'h1, 4'hF);
    rd(8'h1C, 32'h0, "flags_tx_w1c");
    uart_tx_ready = 1;
    idle(1);
    chk("tx_handshake_clear", 32'(uart_tx_valid), 0);
    uart_tx_ready = 0;
    rd(8'h00, 32'h1, "status_tx_idle");
    wr(8'h18, 32'h0, 4'hF);
    exp_ret = 0;
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i % 2 == 0);
      if (inst_retire) exp_ret++;
      idle(1);
    end
    inst_retire = 0;
    rd(8'h10, 32'd100, "cycle_count");
    rd(8'h14, 32'(exp_ret), "retired_count");
    inst_retire = 1;
    wr(8'h18, 32'h0, 4'hF);
    inst_retire = 0;
    rd(8'h10, 32'h0, "cycle_after_clear");
    rd(8'h14, 32'h0, "retired_after_clear");
    for (int i = 0; i < 9; i++) begin
      buttons = (i % 2 == 0) ? 3'b010 : 3'b001;
      idle(1);
      buttons = 0;
      idle(1);
    end
    rd(8'h20, 32'h0, "btn_nonempty");
    rd(8'h1C, 32'h4, "flags_btn_ovf");
    for (int i = 0; i < 8; i++) rd(8'h24, (i % 2 == 0) ? 32'h2 : 32'h1, "btn_pop_order");
    rd(8'h20, 32'h1, "btn_empty");
    rd(8'h24, 32'h0, "btn_pop_empty");
    wr(8'h1C, 32'h4, 4'hF);
    rd(8'h1C, 32'h0, "flags_btn_w1c");
    buttons = 3'b100;
    idle(1);
    buttons = 0;
    idle(1);
    switches = 2'b10;
    rd(8'h28, 32'h2, "switches");
    req_valid = 0; req_addr = 8'h24; req_we = 0;
    idle(1);
    req_addr = 8'h08; req_we = 4'hF; req_wdata = 32'h77;
    idle(1);
    req_we = 0;
    chk("invalid_rsp_hold", rsp_rdata, 32'h2);
    chk("invalid_no_tx", 32'(uart_tx_valid), 0);
    rd(8'h24, 32'h4, "btn_not_popped");
    rd(8'h20, 32'h1, "btn_empty_after");
    wr(8'h30, 32'hFFFF_FFAB, 4'hF);
    chk("leds_written", 32'(leds), 32'h2B);
    wr(8'h30, 32'h0, 4'b0010);
    chk("leds_byte0_only", 32'(leds), 32'h2B);
    rd(8'h30, 32'h2B, "led_readback");
    wr(8'h08, 32'h99, 4'hF);
    chk("tx_loaded_pre_reset", 32'(uart_tx_valid), 1);
    rst = 0;
    idle(1);
    rst = 1;
    chk("midreset_tx_valid", 32'(uart_tx_valid), 0);
    chk("midreset_tx_data", 32'(uart_tx_data), 0);
    chk("midreset_leds", 32'(leds), 0);
    chk("midreset_rsp", rsp_rdata, 0);
    rd(8'h00, 32'h1, "midreset_status");
    idle(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
